spec_free_list: RTL and testbench
=================================

# spec_free_list

Speculative free list for physical registers. It sits between the architectural map table's release port and the rename stage. It takes up to 4 released physical registers per cycle, in commit order, and hands out free physical registers to rename in groups of 4. On recovery, every register allocated speculatively since the last commit is reclaimed in a single cycle.

## Interface
- `SIZE_PHYSICAL`, 96: total physical registers.
- `SIZE_RMT`, 32: logical registers. Physical registers 0..`SIZE_RMT`-1 are architectural at reset.
- `FL_DEPTH`, 64: free list entries. Equals `SIZE_PHYSICAL` - `SIZE_RMT`.
- `PHYS_LOG`, 7: physical tag width.
- `FL_LOG`, 6: pointer width, log2(`FL_DEPTH`).
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- `recoverFlag_i`, in, 1: exception or branch mispredict recovery.
- `releasedValid0..3_i`, in, 1 each: release slot valid. Slot 0 is the oldest.
- `releasedPhyMap0..3_i`, in, `PHYS_LOG` each: released physical tag.
- `reqFreeReg_i`, in, 1: rename requests 4 free registers this cycle.
- `freeReg0..3_o`, out, `PHYS_LOG` each: next 4 free tags, in allocation order.
- `stall_o`, out, 1: fewer than 4 free entries. A request is not honoured while this is high.
- `freeCnt_o`, out, `FL_LOG`+1: current free count.

## Operation
- Storage is a circular buffer with:
  - `head`, the allocation pointer.
  - `tail`, the release pointer.
  - an explicit `count` of 0..`FL_DEPTH`, because `head` == `tail` is ambiguous.
- Reset state:
  - entry i = `SIZE_RMT`+i.
  - `head` = `tail` = 0.
  - `count` = `FL_DEPTH`.
  - `stall_o` = 0, `freeCnt_o` = 64.
  - `freeReg0..3_o` = 32, 33, 34, 35.
- Outputs:
  - `freeRegN_o` = entry[(`head`+N) mod `FL_DEPTH`], combinational from the pointer.
  - `stall_o` = (`count` < 4), based on the current count only. Same-cycle releases do not lift the stall.
- Allocate: when `reqFreeReg_i` and not `stall_o` and not `recoverFlag_i`, `head` advances by 4 and `count` drops by 4.
- Release:
  - Valid slots are compacted in slot order.
  - The k-th valid slot (k = 0..3) writes entry[(`tail`+k) mod `FL_DEPTH`].
  - `tail` and `count` each advance by popcount(valid).
  - Invalid slots leave holes in neither storage nor pointers.
  - Example: valid pattern 1010 writes 2 consecutive entries.
- Count update: `count_next` = `count` - 4·alloc + popcount(valid). All pointer arithmetic is modulo `FL_DEPTH` and wraps naturally.
- Overflow: `count_next` > `FL_DEPTH` is a protocol violation. Flag it with an assertion. The RTL does not guard against it.
- Recovery:
  - Entries between `tail` and `head` still hold the speculatively allocated tags, because `tail` is always at or behind the oldest uncommitted allocation.
  - On `recoverFlag_i`, that cycle's releases are still written.
  - `head_next` = `tail_next`, `count_next` = `FL_DEPTH`.
  - Any allocation request that cycle is dropped.
- Reset mid-operation restores the full reset state regardless of pointer values.

## Timing
- Free tags are valid combinationally in the same cycle the request is made. Allocation commits at the rising edge.
- A released tag is writable at edge t and visible on `freeRegN_o` from cycle t+1 at the earliest, once `head` reaches it.
- Recovery takes 1 cycle. In the cycle after `recoverFlag_i`, `freeCnt_o` = 64 and `stall_o` = 0.
- Simultaneous allocate and release: both apply in the same cycle, and `count` is net-updated.
- Recovery dominates allocate. Release is never dropped.

## Structure
- Shared package holds:
  - `SIZE_PHYSICAL`, `SIZE_RMT`, `FL_DEPTH`, `PHYS_LOG`, `FL_LOG`.
  - A `phys_tag_t` typedef.
- One sub-module, `spec_free_list_ram`:
  - 4 read ports and 4 write ports, `FL_DEPTH`×`PHYS_LOG`.
  - Synchronous write, combinational read.
  - Reset initialises contents.
- The compaction prefix-sum and pointer/count logic live in the top level.

## Test plan
- Reset: `freeReg0..3_o` = 32, 33, 34, 35; `freeCnt_o` = 64; `stall_o` = 0.
- Drain: assert `reqFreeReg_i` for 16 cycles.
  - Cycle 15 presents 92, 93, 94, 95.
  - Afterwards `freeCnt_o` = 0 and `stall_o` = 1.
  - A 17th request leaves `head` unchanged.
- Sparse release plus wrap: after the drain, release valid=1010 with tags slot1=5 and slot3=7.
  - Entries 0 and 1 get 5 and 7; `freeCnt_o` = 2; `stall_o` stays 1.
  - Then release 1, 2 on slots 0 and 2: `freeCnt_o` = 4, `stall_o` = 0.
  - Next outputs are 5, 7, 1, 2.
- Stall boundary: with `count` = 3, request and release 4 tags in the same cycle.
  - No allocation; `freeCnt_o` = 7.
  - Next-cycle request succeeds; `freeCnt_o` = 3.
- Recovery: from reset, allocate 3 groups (32..43), then release tags 0, 1 in one cycle with `recoverFlag_i`=1.
  - Next cycle: `freeCnt_o` = 64; `freeReg0..3_o` = 34, 35, 36, 37.
- Recovery with a concurrent request: `reqFreeReg_i`=1 and a release of tag 9 in the recovery cycle.
  - The request is ignored.
  - Tag 9 lands at `tail`; `count` = 64.
- Reset mid-run: after random traffic, pulse `reset` for 1 cycle. All reset values return.

Source files
------------

// File: rtl/spec_free_list_pkg.sv
// Shared sizing constants and tag/pointer types for the speculative free list.
package spec_free_list_pkg;

    localparam int SIZE_PHYSICAL = 96;
    localparam int SIZE_RMT      = 32;
    localparam int FL_DEPTH      = SIZE_PHYSICAL - SIZE_RMT;
    localparam int PHYS_LOG      = 7;
    localparam int FL_LOG        = 6;
    localparam int NUM_PORTS     = 4;

    typedef logic [PHYS_LOG-1:0] phys_tag_t;
    typedef logic [FL_LOG-1:0]   fl_ptr_t;
    typedef logic [FL_LOG:0]     fl_cnt_t;

endpackage

// File: rtl/spec_free_list_ram.sv
// Free-list storage: 4 combinational read ports, 4 synchronous write ports,
// contents preloaded with the non-architectural tags on reset.
module spec_free_list_ram
    import spec_free_list_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  fl_ptr_t   rd_addr_i [NUM_PORTS],
    output phys_tag_t rd_data_o [NUM_PORTS],
    input  logic      wr_en_i   [NUM_PORTS],
    input  fl_ptr_t   wr_addr_i [NUM_PORTS],
    input  phys_tag_t wr_data_i [NUM_PORTS]
);

    phys_tag_t mem_q [FL_DEPTH];

    // NOTE: the memory is reset on purpose -- the initial free list must hold
    // exactly SIZE_RMT..SIZE_PHYSICAL-1, so this stays a register array.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem_q[i] <= phys_tag_t'(SIZE_RMT + i);
            end
        end else begin
            // Write addresses within a cycle are always distinct (consecutive from tail).
            for (int w = 0; w < NUM_PORTS; w++) begin
                if (wr_en_i[w]) begin
                    mem_q[wr_addr_i[w]] <= wr_data_i[w];
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_PORTS; r++) begin
            rd_data_o[r] = mem_q[rd_addr_i[r]];
        end
    end

endmodule

// File: rtl/spec_free_list.sv
// Speculative physical-register free list: releases up to 4 tags per cycle,
// allocates groups of 4, and rewinds head to tail in one cycle on recovery.
module spec_free_list
    import spec_free_list_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            recoverFlag_i,
    input  logic            releasedValid0_i,
    input  logic            releasedValid1_i,
    input  logic            releasedValid2_i,
    input  logic            releasedValid3_i,
    input  phys_tag_t       releasedPhyMap0_i,
    input  phys_tag_t       releasedPhyMap1_i,
    input  phys_tag_t       releasedPhyMap2_i,
    input  phys_tag_t       releasedPhyMap3_i,
    input  logic            reqFreeReg_i,
    output phys_tag_t       freeReg0_o,
    output phys_tag_t       freeReg1_o,
    output phys_tag_t       freeReg2_o,
    output phys_tag_t       freeReg3_o,
    output logic            stall_o,
    output logic [FL_LOG:0] freeCnt_o
);

    localparam fl_cnt_t FULL_CNT  = fl_cnt_t'(FL_DEPTH);
    localparam fl_cnt_t GROUP_CNT = fl_cnt_t'(NUM_PORTS);
    localparam fl_ptr_t GROUP_PTR = fl_ptr_t'(NUM_PORTS);

    fl_ptr_t   head_q, head_d;
    fl_ptr_t   tail_q, tail_d;
    fl_cnt_t   count_q, count_d;
    fl_cnt_t   count_sum;
    logic      alloc;
    logic [2:0] rel_cnt;

    logic      valid   [NUM_PORTS];
    phys_tag_t rel_tag [NUM_PORTS];
    fl_ptr_t   rd_addr [NUM_PORTS];
    phys_tag_t rd_data [NUM_PORTS];
    logic      wr_en   [NUM_PORTS];
    fl_ptr_t   wr_addr [NUM_PORTS];
    phys_tag_t wr_data [NUM_PORTS];

    assign valid   = '{releasedValid0_i, releasedValid1_i, releasedValid2_i, releasedValid3_i};
    assign rel_tag = '{releasedPhyMap0_i, releasedPhyMap1_i, releasedPhyMap2_i, releasedPhyMap3_i};

    // Compaction: each valid slot lands at tail plus the number of older valid slots.
    // NOTE: rel_cnt is a running sum inside one combinational pass, so it is
    // assigned with blocking '=' and given a default before the loop.
    always_comb begin
        rel_cnt = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            wr_en[k]   = valid[k];
            wr_addr[k] = tail_q + fl_ptr_t'(rel_cnt);
            wr_data[k] = rel_tag[k];
            rel_cnt    = rel_cnt + {2'b00, valid[k]};
        end
    end

    always_comb begin
        for (int n = 0; n < NUM_PORTS; n++) begin
            rd_addr[n] = head_q + fl_ptr_t'(n);
        end
    end

    assign stall_o   = (count_q < GROUP_CNT);
    assign alloc     = reqFreeReg_i && !stall_o && !recoverFlag_i;
    assign tail_d    = tail_q + fl_ptr_t'(rel_cnt);
    assign count_sum = count_q + fl_cnt_t'(rel_cnt) - (alloc ? GROUP_CNT : '0);

    // Recovery rewinds head onto the post-release tail; releases still commit.
    always_comb begin
        head_d  = head_q;
        count_d = count_sum;
        if (alloc) begin
            head_d = head_q + GROUP_PTR;
        end
        if (recoverFlag_i) begin
            head_d  = tail_d;
            count_d = FULL_CNT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= FULL_CNT;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    spec_free_list_ram u_ram (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data)
    );

    assign freeReg0_o = rd_data[0];
    assign freeReg1_o = rd_data[1];
    assign freeReg2_o = rd_data[2];
    assign freeReg3_o = rd_data[3];
    assign freeCnt_o  = count_q;

    // Releasing more tags than were ever allocated is a caller bug.
    overflow_a: assert property (@(posedge clk) disable iff (reset)
        !recoverFlag_i |-> (count_sum <= FULL_CNT));

endmodule

// File: tb/tb_spec_free_list.sv
// Self-checking bench for spec_free_list: directed scenarios plus random
// traffic compared against a queue-based model of free and in-flight tags.
module tb_spec_free_list;
    import spec_free_list_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            recoverFlag_i;
    logic            reqFreeReg_i;
    logic            releasedValid0_i, releasedValid1_i, releasedValid2_i, releasedValid3_i;
    phys_tag_t       releasedPhyMap0_i, releasedPhyMap1_i, releasedPhyMap2_i, releasedPhyMap3_i;
    phys_tag_t       freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o;
    logic            stall_o;
    logic [FL_LOG:0] freeCnt_o;

    int compared   = 0;
    int mismatched = 0;

    // Model: free_q holds tags in allocation order; used_q holds allocated
    // tags oldest-first whose slots have not yet been overwritten by releases.
    int free_q[$];
    int used_q[$];

    always #5 clk = ~clk;

    spec_free_list dut (
        .clk               (clk),
        .reset             (reset),
        .recoverFlag_i     (recoverFlag_i),
        .releasedValid0_i  (releasedValid0_i),
        .releasedValid1_i  (releasedValid1_i),
        .releasedValid2_i  (releasedValid2_i),
        .releasedValid3_i  (releasedValid3_i),
        .releasedPhyMap0_i (releasedPhyMap0_i),
        .releasedPhyMap1_i (releasedPhyMap1_i),
        .releasedPhyMap2_i (releasedPhyMap2_i),
        .releasedPhyMap3_i (releasedPhyMap3_i),
        .reqFreeReg_i      (reqFreeReg_i),
        .freeReg0_o        (freeReg0_o),
        .freeReg1_o        (freeReg1_o),
        .freeReg2_o        (freeReg2_o),
        .freeReg3_o        (freeReg3_o),
        .stall_o           (stall_o),
        .freeCnt_o         (freeCnt_o)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        free_q.delete();
        used_q.delete();
        for (int i = 0; i < FL_DEPTH; i++) free_q.push_back(SIZE_RMT + i);
    endtask

    // The whole ring read from head: free tags, then the in-flight ones.
    function automatic int model_ring(input int n);
        if (n < free_q.size()) return free_q[n];
        return used_q[n - free_q.size()];
    endfunction

    task automatic check_model(input string tag);
        logic [31:0] fr [4];
        fr = '{32'(freeReg0_o), 32'(freeReg1_o), 32'(freeReg2_o), 32'(freeReg3_o)};
        chk({tag, ".cnt"}, 32'(freeCnt_o), free_q.size());
        chk({tag, ".stall"}, 32'(stall_o), (free_q.size() < 4) ? 1 : 0);
        for (int n = 0; n < 4; n++) chk($sformatf("%s.freeReg%0d", tag, n), fr[n], model_ring(n));
    endtask

    task automatic check_const(input string tag, input int f0, input int f1, input int f2,
                               input int f3, input int cnt, input int stl);
        chk({tag, ".freeReg0"}, 32'(freeReg0_o), f0);
        chk({tag, ".freeReg1"}, 32'(freeReg1_o), f1);
        chk({tag, ".freeReg2"}, 32'(freeReg2_o), f2);
        chk({tag, ".freeReg3"}, 32'(freeReg3_o), f3);
        chk({tag, ".cnt"}, 32'(freeCnt_o), cnt);
        chk({tag, ".stall"}, 32'(stall_o), stl);
    endtask

    task automatic drive(input logic req, input logic rec, input logic [3:0] v,
                         input int t0, input int t1, input int t2, input int t3);
        reqFreeReg_i      = req;
        recoverFlag_i     = rec;
        releasedValid0_i  = v[0];
        releasedValid1_i  = v[1];
        releasedValid2_i  = v[2];
        releasedValid3_i  = v[3];
        releasedPhyMap0_i = phys_tag_t'(t0);
        releasedPhyMap1_i = phys_tag_t'(t1);
        releasedPhyMap2_i = phys_tag_t'(t2);
        releasedPhyMap3_i = phys_tag_t'(t3);
    endtask

    // One clock: drive, check the combinational view mid-cycle, then apply the edge to the model.
    task automatic step(input string tag, input logic req, input logic rec, input logic [3:0] v,
                        input int t0, input int t1, input int t2, input int t3);
        int tags [4];
        tags = '{t0, t1, t2, t3};
        drive(req, rec, v, t0, t1, t2, t3);
        #3;
        check_model(tag);
        @(posedge clk);
        if (req && !rec && free_q.size() >= 4) begin
            for (int k = 0; k < 4; k++) used_q.push_back(free_q.pop_front());
        end
        for (int k = 0; k < 4; k++) begin
            if (v[k]) begin
                // The slot at tail is the oldest in-flight one, or the head when none are in flight.
                if (used_q.size() > 0) void'(used_q.pop_front());
                else void'(free_q.pop_front());
                free_q.push_back(tags[k]);
            end
        end
        if (rec) begin
            while (used_q.size() > 0) free_q.push_front(used_q.pop_back());
        end
        #1;
        drive(1'b0, 1'b0, 4'b0000, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 4'b0000, 0, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        do_reset();
        check_const("reset", 32, 33, 34, 35, 64, 0);
        check_model("reset_model");

        // Drain the whole list in 16 groups.
        for (int i = 0; i < 15; i++) step($sformatf("drain%0d", i), 1'b1, 1'b0, 4'b0000, 0, 0, 0, 0);
        check_const("drain15_view", 92, 93, 94, 95, 4, 0);
        step("drain15", 1'b1, 1'b0, 4'b0000, 0, 0, 0, 0);
        check_const("drained", 32, 33, 34, 35, 0, 1);
        step("req17", 1'b1, 1'b0, 4'b0000, 0, 0, 0, 0);
        check_const("after_req17", 32, 33, 34, 35, 0, 1);

        // Sparse release across the wrap point.
        step("sparse1010", 1'b0, 1'b0, 4'b1010, 0, 5, 0, 7);
        check_const("sparse1010_post", 5, 7, 34, 35, 2, 1);
        step("sparse0101", 1'b0, 1'b0, 4'b0101, 1, 0, 2, 0);
        check_const("sparse0101_post", 5, 7, 1, 2, 4, 0);

        // Stall boundary: request with count 3 plus a same-cycle release of 4.
        step("bnd_alloc", 1'b1, 1'b0, 4'b0000, 0, 0, 0, 0);
        step("bnd_rel3", 1'b0, 1'b0, 4'b0111, 10, 11, 12, 0);
        check_const("bnd_cnt3", 10, 11, 12, 39, 3, 1);
        step("bnd_req_rel4", 1'b1, 1'b0, 4'b1111, 20, 21, 22, 23);
        check_const("bnd_no_alloc", 10, 11, 12, 20, 7, 0);
        step("bnd_req", 1'b1, 1'b0, 4'b0000, 0, 0, 0, 0);
        chk("bnd_after_req.cnt", 32'(freeCnt_o), 3);
        check_model("bnd_after_req");

        // Recovery from reset after 3 groups, with two releases in the recovery cycle.
        do_reset();
        for (int i = 0; i < 3; i++) step($sformatf("rec_alloc%0d", i), 1'b1, 1'b0, 4'b0000, 0, 0, 0, 0);
        step("recover", 1'b0, 1'b1, 4'b0011, 0, 1, 0, 0);
        check_const("recover_post", 34, 35, 36, 37, 64, 0);

        // Recovery with a concurrent request and a release of tag 9.
        step("recover_req", 1'b1, 1'b1, 4'b0001, 9, 0, 0, 0);
        check_const("recover_req_post", 35, 36, 37, 38, 64, 0);
        check_model("recover_req_model");

        // Random traffic, releases limited so the free count never exceeds the depth.
        for (int c = 0; c < 400; c++) begin
            logic       rec;
            logic       req;
            logic [3:0] v;
            int         lim;
            int         t [4];
            rec = ($urandom_range(15) == 0);
            req = ($urandom_range(9) < 6);
            lim = used_q.size() + ((req && !rec && free_q.size() >= 4) ? 4 : 0);
            v   = 4'($urandom_range(15));
            for (int k = 3; k >= 0; k--) begin
                if ($countones(v) > lim) v[k] = 1'b0;
            end
            for (int k = 0; k < 4; k++) t[k] = $urandom_range(SIZE_PHYSICAL - 1);
            step($sformatf("rand%0d", c), req, rec, v, t[0], t[1], t[2], t[3]);
        end

        // Reset in the middle of traffic restores everything.
        step("pre_reset", 1'b1, 1'b0, 4'b0000, 0, 0, 0, 0);
        do_reset();
        check_const("midrun_reset", 32, 33, 34, 35, 64, 0);
        step("midrun_reset_step", 1'b1, 1'b0, 4'b0000, 0, 0, 0, 0);
        check_const("midrun_reset_alloc", 36, 37, 38, 39, 60, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
